// File: rtl/sipo_deframer_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deframer.
// Optional feature macro: SIPO_PARITY_EN (one even-parity bit per frame).
package sipo_pkg;

    typedef enum logic {IDLE, SHIFT} sipo_state_t;

    // Number of serial bits per frame: data bits, plus one parity bit when enabled.
    function automatic int unsigned frame_bits(input int unsigned width);
`ifdef SIPO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial input and parallel valid/ready output bundle of the deframer.
// slave is the deframer side, master is the producer/consumer side.
interface sipo_deframer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             sof;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             parity_err;

    modport slave (
        input  sin, sin_valid, sof, pout_ready,
        output pout, pout_valid, parity_err
    );

    modport master (
        output sin, sin_valid, sof, pout_ready,
        input  pout, pout_valid, parity_err
    );
endinterface

// File: rtl/sipo_deframer_out_reg.sv
// Output holding register: pout/pout_valid/parity_err with valid/ready
// handshake and the sticky overrun flag.
module sipo_out_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             word_perr,
    input  logic             pout_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             parity_err,
    output logic             overrun
);

    logic can_load;

    // Register is free when empty or being drained this cycle.
    always_comb begin
        can_load = !pout_valid || pout_ready;
    end

    // Hold, load or release the output word; track dropped words.
    always_ff @(posedge clk) begin
        if (rst) begin
            pout       <= '0;
            pout_valid <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load && can_load) begin
                pout       <= word;
                parity_err <= word_perr;
                pout_valid <= 1'b1;
            end else if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end

            if (load && !can_load) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// MSB-first serial-to-parallel deframer with start-of-frame delimiting.
// Optional feature macro: SIPO_PARITY_EN (adds an even-parity bit per frame).
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    sipo_deframer_if.slave      bus,
    output logic                overrun,
    output logic                frame_err,
    input  logic                err_clr
);

    localparam int unsigned FRAME_BITS = frame_bits(WIDTH);
    localparam int unsigned CW         = $clog2(WIDTH + 2);
    localparam int unsigned SW         = FRAME_BITS - 1;
    localparam logic [CW-1:0] LAST     = CW'(FRAME_BITS - 1);

    sipo_state_t       state;
    logic [SW-1:0]     shreg;
    logic [CW-1:0]     cnt;
    logic [FRAME_BITS-1:0] frame_nxt;
    logic [WIDTH-1:0]  word;
    logic              word_perr;
    logic              done;

    // Shift register only keeps the bits needed to assemble a frame together
    // with the bit arriving on the completing cycle; the full frame is frame_nxt.
    always_comb begin
        frame_nxt = {shreg, bus.sin};
        word      = frame_nxt[FRAME_BITS-1 -: WIDTH];
`ifdef SIPO_PARITY_EN
        word_perr = ^frame_nxt;
`else
        word_perr = 1'b0;
`endif
        done      = bus.sin_valid && !bus.sof && (state == SHIFT) && (cnt == LAST);
    end

    // Frame FSM, shifter, bit counter and sticky framing-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            if (bus.sin_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.sof) begin
                            shreg <= frame_nxt[SW-1:0];
                            cnt   <= CW'(1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        shreg <= frame_nxt[SW-1:0];
                        if (bus.sof) begin
                            cnt <= CW'(1);
                        end else if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (bus.sin_valid && bus.sof && (state == SHIFT)) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (done),
        .word       (word),
        .word_perr  (word_perr),
        .pout_ready (bus.pout_ready),
        .err_clr    (err_clr),
        .pout       (bus.pout),
        .pout_valid (bus.pout_valid),
        .parity_err (bus.parity_err),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed self-checking bench for sipo_deframer (WIDTH=4).
// Honours SIPO_PARITY_EN: frames get an even-parity bit and the parity test runs.
module tb_sipo_deframer;
    import sipo_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned FB = frame_bits(W);

    logic clk;
    logic rst;
    logic err_clr;
    logic overrun;
    logic frame_err;

    int passed;
    int total;

    sipo_deframer_if #(.WIDTH(W)) bus ();

    sipo_deframer #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One valid serial bit, sampled on the next rising edge; returns 1 ns after it.
    task automatic bit_in(input logic b, input logic s);
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        bus.sof       = s;
        @(posedge clk);
        #1;
        bus.sin_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.sin       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send frame bits [from, to) of word w with parity bit p; gap idle cycles between bits.
    task automatic send_part(input logic [3:0] w, input logic p, input int from, input int to,
                             input int gap);
        logic b;
        for (int i = from; i < to; i++) begin
            b = (i < 4) ? w[3 - i] : p;
            bit_in(b, (i == 0));
            if (gap > 0 && i < to - 1) idle(gap);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        total++; if (bus.pout_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.pout_valid); else passed++;
        total++; if (bus.pout !== 4'h0) $display("FAIL reset_pout got=%h exp=0", bus.pout); else passed++;
        total++; if ({overrun, frame_err, bus.parity_err} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {overrun, frame_err, bus.parity_err}); else passed++;
    endtask

    task automatic test_basic();
        bus.pout_ready = 1'b1;
        send_part(4'b1011, 1'b1, 0, FB - 1, 0);
        total++; if (bus.pout_valid !== 1'b0) $display("FAIL basic_early got=%b exp=0", bus.pout_valid); else passed++;
        send_part(4'b1011, 1'b1, FB - 1, FB, 0);
        total++; if (bus.pout_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", bus.pout_valid); else passed++;
        total++; if (bus.pout !== 4'b1011) $display("FAIL basic_pout got=%b exp=1011", bus.pout); else passed++;
        total++; if ({overrun, frame_err, bus.parity_err} !== 3'b000)
            $display("FAIL basic_flags got=%b exp=000", {overrun, frame_err, bus.parity_err}); else passed++;
        idle(1);
        total++; if (bus.pout_valid !== 1'b0) $display("FAIL basic_drop got=%b exp=0", bus.pout_valid); else passed++;
    endtask

    task automatic test_gaps();
        bus.pout_ready = 1'b1;
        send_part(4'b1011, 1'b1, 0, FB - 1, 2);
        idle(2);
        total++; if (bus.pout_valid !== 1'b0) $display("FAIL gaps_early got=%b exp=0", bus.pout_valid); else passed++;
        send_part(4'b1011, 1'b1, FB - 1, FB, 0);
        total++; if (bus.pout_valid !== 1'b1 || bus.pout !== 4'b1011)
            $display("FAIL gaps_word got=%b/%b exp=1/1011", bus.pout_valid, bus.pout); else passed++;
        idle(1);
        total++; if (bus.pout_valid !== 1'b0) $display("FAIL gaps_drop got=%b exp=0", bus.pout_valid); else passed++;
    endtask

    task automatic test_overrun();
        bus.pout_ready = 1'b0;
        send_part(4'hA, 1'b0, 0, FB, 0);
        total++; if (bus.pout_valid !== 1'b1 || bus.pout !== 4'hA)
            $display("FAIL ovr_first got=%b/%h exp=1/a", bus.pout_valid, bus.pout); else passed++;
        send_part(4'h5, 1'b0, 0, FB, 0);
        total++; if (bus.pout !== 4'hA) $display("FAIL ovr_hold got=%h exp=a", bus.pout); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", overrun); else passed++;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        total++; if (overrun !== 1'b0) $display("FAIL ovr_clr got=%b exp=0", overrun); else passed++;
        total++; if (bus.pout_valid !== 1'b1 || bus.pout !== 4'hA)
            $display("FAIL ovr_still got=%b/%h exp=1/a", bus.pout_valid, bus.pout); else passed++;
        bus.pout_ready = 1'b1;
        idle(1);
        total++; if (bus.pout_valid !== 1'b0) $display("FAIL ovr_accept got=%b exp=0", bus.pout_valid); else passed++;
    endtask

    task automatic test_frame_err();
        bus.pout_ready = 1'b1;
        send_part(4'b1100, 1'b0, 0, 2, 0);
        send_part(4'b0110, 1'b0, 0, 1, 0);
        total++; if (frame_err !== 1'b1) $display("FAIL ferr_set got=%b exp=1", frame_err); else passed++;
        total++; if (bus.pout_valid !== 1'b0) $display("FAIL ferr_nopart got=%b exp=0", bus.pout_valid); else passed++;
        send_part(4'b0110, 1'b0, 1, FB, 0);
        total++; if (bus.pout_valid !== 1'b1 || bus.pout !== 4'b0110)
            $display("FAIL ferr_word got=%b/%b exp=1/0110", bus.pout_valid, bus.pout); else passed++;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        total++; if (frame_err !== 1'b0 || bus.pout_valid !== 1'b0)
            $display("FAIL ferr_clr got=%b/%b exp=0/0", frame_err, bus.pout_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        bus.pout_ready = 1'b0;
        send_part(4'h9, 1'b0, 0, FB, 0);
        send_part(4'hC, 1'b0, 0, FB - 1, 0);
        total++; if (bus.pout !== 4'h9 || bus.pout_valid !== 1'b1)
            $display("FAIL b2b_hold got=%b/%h exp=1/9", bus.pout_valid, bus.pout); else passed++;
        bus.pout_ready = 1'b1;
        send_part(4'hC, 1'b0, FB - 1, FB, 0);
        total++; if (bus.pout !== 4'hC || bus.pout_valid !== 1'b1)
            $display("FAIL b2b_load got=%b/%h exp=1/c", bus.pout_valid, bus.pout); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL b2b_ovr got=%b exp=0", overrun); else passed++;
        idle(1);
        total++; if (bus.pout_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", bus.pout_valid); else passed++;
    endtask

    task automatic test_mid_reset();
        bus.pout_ready = 1'b0;
        send_part(4'hA, 1'b0, 0, FB, 0);
        send_part(4'h5, 1'b0, 0, FB, 0);
        send_part(4'h3, 1'b0, 0, 2, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        total++; if ({bus.pout_valid, bus.pout, bus.parity_err, overrun, frame_err} !== 8'h00)
            $display("FAIL mrst_zero got=%b exp=00000000",
                     {bus.pout_valid, bus.pout, bus.parity_err, overrun, frame_err}); else passed++;
        bus.pout_ready = 1'b1;
        send_part(4'b1011, 1'b1, 0, FB, 0);
        total++; if (bus.pout_valid !== 1'b1 || bus.pout !== 4'b1011 || frame_err !== 1'b0)
            $display("FAIL mrst_clean got=%b/%b/%b exp=1/1011/0", bus.pout_valid, bus.pout, frame_err);
        else passed++;
        idle(1);
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        bus.pout_ready = 1'b1;
        send_part(4'b1011, 1'b1, 0, FB, 0);
        total++; if (bus.pout !== 4'b1011 || bus.parity_err !== 1'b0)
            $display("FAIL par_good got=%b/%b exp=1011/0", bus.pout, bus.parity_err); else passed++;
        idle(1);
        send_part(4'b1011, 1'b0, 0, FB, 0);
        total++; if (bus.pout !== 4'b1011 || bus.parity_err !== 1'b1)
            $display("FAIL par_bad got=%b/%b exp=1011/1", bus.pout, bus.parity_err); else passed++;
        idle(1);
    endtask
`endif

    initial begin
        passed         = 0;
        total          = 0;
        rst            = 1'b1;
        err_clr        = 1'b0;
        bus.sin        = 1'b0;
        bus.sin_valid  = 1'b0;
        bus.sof        = 1'b0;
        bus.pout_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_frame_err();
        test_back_to_back();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
